bus_arbiter_rr: RTL and testbench

// - Parametrised N-core shared-memory bus. Successor to the fixed two-core bus.
// - Round-robin arbitration across NUM_CORES requesters for the gpiomem RAM port.
// - A hold-timeout forces release, so one core cannot starve the others.
// - Per-core read-valid strobes tell each core when its read data is on the bus.

---
 rtl/bus_arbiter_rr.sv | 184 ++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter giving NUM_CORES cores shared access to one synchronous RAM
// port. A grant is released when the owner drops its request, or when the owner has held
// the bus for MAX_HOLD consecutive cycles. A timeout release is followed by one dead cycle.
//
// Optional feature: define BUS_LOCK_EN to add core_lock. While the owner's lock bit is high,
// the hold timeout is suppressed.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low reset
//   core_request  per-core bus request
//   core_grant    registered one-hot (or zero) grant
//   core_rw       per-core access type, 1 = write
//   core_lock     per-core timeout suppression (BUS_LOCK_EN only)
//   core_address  packed core addresses, core i at [i*ADDR_W +: ADDR_W]
//   core_wdata    packed core write data, core i at [i*DATA_W +: DATA_W]
//   core_rdata    read data broadcast to all cores
//   core_rvalid   one-cycle strobe marking core_rdata valid for core i
//   RAM_address   RAM address, the low RAM_ADDR_W bits of the owner's address
//   RAM_data_in   RAM write data
//   RAM_data_out  RAM read data, one-cycle read latency
//   rw            RAM write enable
module bus_arbiter_rr #(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RAM_ADDR_W = 9,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_request,
  output logic [NUM_CORES-1:0]          core_grant,
  input  logic [NUM_CORES-1:0]          core_rw,
`ifdef BUS_LOCK_EN
  input  logic [NUM_CORES-1:0]          core_lock,
`endif
  input  logic [NUM_CORES*ADDR_W-1:0]   core_address,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [DATA_W-1:0]             core_rdata,
  output logic [NUM_CORES-1:0]          core_rvalid,
  output logic [RAM_ADDR_W-1:0]         RAM_address,
  output logic [DATA_W-1:0]             RAM_data_in,
  input  logic [DATA_W-1:0]             RAM_data_out,
  output logic                          rw
);

  localparam int unsigned IdxW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MAX_HOLD - 1);
  localparam logic [IdxW-1:0]  LastCore = IdxW'(NUM_CORES - 1);

  typedef enum logic [1:0] {StIdle, StOwn, StPark} state_e;

  state_e                 state_q, state_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;

  // Round-robin pick: first requester at or after ptr_q, wrapping.
  logic                   found;
  logic [IdxW-1:0]        winner;
  int unsigned            cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!found && core_request[cand[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

  logic [IdxW-1:0] next_ptr;
  assign next_ptr = (owner_q == LastCore) ? '0 : owner_q + 1'b1;

  logic locked;
`ifdef BUS_LOCK_EN
  assign locked = core_lock[owner_q];
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d         = StOwn;
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          hold_d          = '0;
        end
      end
      StOwn: begin
        if (!core_request[owner_q]) begin
          grant_d = '0;
          ptr_d   = next_ptr;
          state_d = StIdle;
        end else if (locked) begin
          // Saturate so that unlocking at the limit times out on the following cycle.
          if (hold_q != HoldMax) hold_d = hold_q + 1'b1;
        end else if (hold_q == HoldMax) begin
          grant_d = '0;
          ptr_d   = next_ptr;
          state_d = StPark;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StPark: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // A read issued while granted returns its data one cycle later, even after release.
  assign rvalid_d = grant_q & ~core_rw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
    end
  end

  // One-hot AND-OR mux from the owner; all zero when nobody holds the grant.
  logic [RAM_ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0]     wdata_mux;
  logic                  rw_mux;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    rw_mux    = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant_q[i]) begin
        addr_mux  = core_address[i*ADDR_W +: RAM_ADDR_W];
        wdata_mux = core_wdata[i*DATA_W +: DATA_W];
        rw_mux    = core_rw[i];
      end
    end
  end

  assign RAM_address = addr_mux;
  assign RAM_data_in = wdata_mux;
  // Gating with reset drops a write that coincides with the reset edge.
  assign rw          = rw_mux & reset;
  assign core_grant  = grant_q;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = RAM_data_out;

  // Upper core address bits beyond RAM_ADDR_W are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core_address;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req, grant, crw, rvalid;
  logic [19:0] caddr;
  logic [15:0] cwdata;
  logic [7:0]  rdata, ram_din, ram_dout;
  logic [8:0]  ram_addr;
  logic        rw;
`ifdef BUS_LOCK_EN
  logic [1:0]  lock;
  logic [3:0]  lock4;
`endif

  // Four-core instance for the pointer wrap scenario.
  logic [3:0]  req4, grant4;
  logic [3:0]  unused_rvalid4;
  logic [7:0]  unused_rdata4, unused_din4;
  logic [8:0]  unused_addr4;
  logic        unused_rw4;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  logic [7:0] mem [512];
  logic [7:0] model_mem [512];
  logic [7:0] exp_q[$];
  int         exp_core_q[$];

  bus_arbiter_rr dut (
    .clk          (clk),
    .reset        (reset),
    .core_request (req),
    .core_grant   (grant),
    .core_rw      (crw),
`ifdef BUS_LOCK_EN
    .core_lock    (lock),
`endif
    .core_address (caddr),
    .core_wdata   (cwdata),
    .core_rdata   (rdata),
    .core_rvalid  (rvalid),
    .RAM_address  (ram_addr),
    .RAM_data_in  (ram_din),
    .RAM_data_out (ram_dout),
    .rw           (rw)
  );

  bus_arbiter_rr #(.NUM_CORES(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .core_request (req4),
    .core_grant   (grant4),
    .core_rw      (4'b0000),
`ifdef BUS_LOCK_EN
    .core_lock    (lock4),
`endif
    .core_address (40'd0),
    .core_wdata   (32'd0),
    .core_rdata   (unused_rdata4),
    .core_rvalid  (unused_rvalid4),
    .RAM_address  (unused_addr4),
    .RAM_data_in  (unused_din4),
    .RAM_data_out (8'h00),
    .rw           (unused_rw4)
  );

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (rw) begin
      mem[ram_addr] <= ram_din;
      wr_cnt        <= wr_cnt + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    req4  = '0;
    crw   = '0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic wait_grant(input int c, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      tick();
      if (grant[c]) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_grant core%0d: grant=%b, required bit %0d set", c, grant, c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 2'b11;
    crw   = 2'b00;
    repeat (3) tick();
    n_checks++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b, required 00", grant); end
    n_checks++;
    if (rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b, required 0", rw); end
    n_checks++;
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b, required 00", rvalid); end
    n_checks++;
    if (ram_addr !== 9'd0) begin n_fail++; $display("FAIL reset_addr: got %h, required 000", ram_addr); end
    reset = 1'b1;
    tick();
    n_checks++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant: got %b, required 01", grant); end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    apply_reset();
    crw = 2'b00;
    req = 2'b11;
    for (int k = 1; k <= 54; k++) begin
      tick();
      if (((k - 1) % 18) >= 16) exp = 2'b00;
      else if ((((k - 1) / 18) % 2) == 0) exp = 2'b01;
      else exp = 2'b10;
      n_checks++;
      if (grant !== exp) begin
        n_fail++;
        $display("FAIL contention cycle %0d: grant=%b, required %b", k, grant, exp);
      end
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic do_write(input int c, input logic [9:0] a, input logic [7:0] d);
    bit ok;
    caddr[c*AW +: AW] = a;
    cwdata[c*8 +: 8]  = d;
    crw[c]            = 1'b1;
    req[c]            = 1'b1;
    wait_grant(c, ok);
    if (ok) begin
      n_checks++;
      if (rw !== 1'b1) begin n_fail++; $display("FAIL write_rw core%0d: got %b, required 1", c, rw); end
      n_checks++;
      if (ram_addr !== a[8:0]) begin
        n_fail++; $display("FAIL write_addr core%0d: got %h, required %h", c, ram_addr, a[8:0]);
      end
      n_checks++;
      if (ram_din !== d) begin
        n_fail++; $display("FAIL write_data core%0d: got %h, required %h", c, ram_din, d);
      end
      model_mem[a[8:0]] = d;
    end
    req[c] = 1'b0;
    tick();
    crw[c] = 1'b0;
    tick();
  endtask

  task automatic do_read(input int c, input logic [9:0] a);
    bit         ok;
    bit         seen;
    logic [7:0] exp_d;
    int         exp_c;
    logic [1:0] exp_v;
    caddr[c*AW +: AW] = a;
    crw[c]            = 1'b0;
    req[c]            = 1'b1;
    wait_grant(c, ok);
    if (ok) begin
      n_checks++;
      if (rw !== 1'b0) begin n_fail++; $display("FAIL read_rw core%0d: got %b, required 0", c, rw); end
      exp_q.push_back(model_mem[a[8:0]]);
      exp_core_q.push_back(c);
    end
    req[c] = 1'b0;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen && exp_q.size() > 0; k++) begin
      if (rvalid !== 2'b00) begin
        seen  = 1'b1;
        exp_d = exp_q.pop_front();
        exp_c = exp_core_q.pop_front();
        exp_v = 2'b00;
        exp_v[exp_c] = 1'b1;
        n_checks++;
        if (rvalid !== exp_v) begin
          n_fail++; $display("FAIL read_rvalid core%0d: got %b, required %b", c, rvalid, exp_v);
        end
        n_checks++;
        if (rdata !== exp_d) begin
          n_fail++; $display("FAIL read_data core%0d: got %h, required %h", c, rdata, exp_d);
        end
        if (k != 0) begin
          n_checks++; n_fail++;
          $display("FAIL read_latency core%0d: strobe after %0d extra cycles, required 0", c, k);
        end
      end else begin
        tick();
      end
    end
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL read_timeout core%0d: rvalid=%b, required a strobe", c, rvalid);
      exp_q.delete();
      exp_core_q.delete();
    end
    tick();
    n_checks++;
    if (rvalid !== 2'b00) begin
      n_fail++; $display("FAIL read_strobe_width core%0d: got %b, required 00", c, rvalid);
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    do_write(1, 10'h005, 8'hA5);
    do_read(1, 10'h005);
    do_write(0, 10'h20A, 8'h5A);
    do_read(1, 10'h00A);
    do_write(1, 10'h1FF, 8'h3C);
    do_read(0, 10'h1FF);
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    crw = 2'b00;
    req = 2'b01;
    wait_grant(0, ok);
    tick();
    req = 2'b10;
    tick();
    n_checks++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL handoff_release: got %b, required 00", grant); end
    tick();
    n_checks++;
    if (grant !== 2'b10) begin n_fail++; $display("FAIL handoff_grant: got %b, required 10", grant); end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_own();
    bit ok;
    int n0;
    apply_reset();
    caddr[AW-1:0] = 10'h010;
    cwdata[7:0]   = 8'h77;
    crw           = 2'b01;
    req           = 2'b01;
    wait_grant(0, ok);
    n0 = wr_cnt;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (rw !== 1'b0) begin n_fail++; $display("FAIL midreset_rw_now: got %b, required 0", rw); end
    tick();
    n_checks++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL midreset_grant: got %b, required 00", grant); end
    n_checks++;
    if (rw !== 1'b0) begin n_fail++; $display("FAIL midreset_rw: got %b, required 0", rw); end
    tick();
    n_checks++;
    if (wr_cnt !== n0 + 1) begin
      n_fail++; $display("FAIL midreset_writes: got %0d, required %0d", wr_cnt - n0, 1);
    end
    n_checks++;
    if (mem[9'h010] !== 8'h77) begin
      n_fail++; $display("FAIL midreset_committed: got %h, required 77", mem[9'h010]);
    end
    req   = 2'b00;
    crw   = 2'b00;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    req4 = 4'b0100;
    ok   = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      tick();
      if (grant4[2]) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_setup: grant=%b, required 0100", grant4); end
    req4 = 4'b0000;
    tick();
    n_checks++;
    if (grant4 !== 4'b0000) begin n_fail++; $display("FAIL wrap_release: got %b, required 0000", grant4); end
    req4 = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (grant4 !== 4'b1000) begin
        n_fail++; $display("FAIL wrap_first cycle %0d: got %b, required 1000", k, grant4);
      end
    end
    req4 = 4'b0010;
    tick();
    n_checks++;
    if (grant4 !== 4'b0000) begin n_fail++; $display("FAIL wrap_gap: got %b, required 0000", grant4); end
    tick();
    n_checks++;
    if (grant4 !== 4'b0010) begin n_fail++; $display("FAIL wrap_second: got %b, required 0010", grant4); end
    req4 = 4'b0000;
    tick();
    tick();
  endtask

`ifdef BUS_LOCK_EN
  task automatic test_lock();
    apply_reset();
    crw  = 2'b00;
    lock = 2'b01;
    req  = 2'b11;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_checks++;
      if (grant !== 2'b01) begin
        n_fail++; $display("FAIL lock_hold cycle %0d: got %b, required 01", k, grant);
      end
    end
    req  = 2'b10;
    lock = 2'b00;
    tick();
    n_checks++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL lock_release: got %b, required 00", grant); end
    tick();
    n_checks++;
    if (grant !== 2'b10) begin n_fail++; $display("FAIL lock_next: got %b, required 10", grant); end
    req = 2'b00;
    tick();
    tick();
  endtask
`endif

  initial begin
    reset  = 1'b0;
    req    = '0;
    req4   = '0;
    crw    = '0;
    caddr  = '0;
    cwdata = '0;
`ifdef BUS_LOCK_EN
    lock   = '0;
    lock4  = '0;
`endif
    test_reset();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_reset_mid_own();
    test_wrap();
`ifdef BUS_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
